// File: rtl/step_calculator_multi.sv
// step_calculator_multi: per-channel step-rate calculator for the silencer.
// Streams DEPTH channel targets per frame and emits the per-update increment
// that reaches each new target in COMPLETION_STEPS updates.
// Latency from accepted beat to output beat is WIDTH + 4 cycles.
// Ports:
//   CLK, RST            clock, synchronous active-high reset (clears state)
//   DIN_VALID, TARGET   one channel beat per cycle when READY is high
//   COMPLETION_STEPS    divisor, captured on the channel 0 beat of a frame
//   READY               low while channel memories are being cleared
//   UPDATE_RATE         per-update increment magnitude
//   DOUT_IDX            channel index of UPDATE_RATE
//   DOUT_VALID          one-cycle strobe per output beat
module step_calculator_multi #(
   parameter int WIDTH      = 16,
   parameter int DEPTH      = 249,
   parameter int PHASE_MODE = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             DIN_VALID,
   input  logic [WIDTH-1:0] COMPLETION_STEPS,
   input  logic [WIDTH-1:0] TARGET,
   output logic             READY,
   output logic [WIDTH-1:0] UPDATE_RATE,
   output logic [7:0]       DOUT_IDX,
   output logic             DOUT_VALID
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] LAST = 8'(DEPTH - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   typedef struct packed {
      logic             vld;
      logic [7:0]       idx;
      logic             chg;
      logic [WIDTH-1:0] tgt;
      logic [WIDTH-1:0] dif;
      logic [WIDTH-1:0] srem;
      logic [WIDTH-1:0] num;
      logic [WIDTH-1:0] den;
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] prem;
   } div_t;

   state_t           r_state;
   logic             r_ready;
   logic [7:0]       r_clr;
   logic [7:0]       r_cnt;
   logic [WIDTH-1:0] r_steps;

   logic [WIDTH-1:0] r_mem_tgt [DEPTH];
   logic [WIDTH-1:0] r_mem_dif [DEPTH];
   logic [WIDTH-1:0] r_mem_rem [DEPTH];

   logic             r_s1_vld;
   logic [7:0]       r_s1_idx;
   logic [WIDTH-1:0] r_s1_tgt;
   logic [WIDTH-1:0] r_s1_steps;
   logic [WIDTH-1:0] r_rd_tgt;
   logic [WIDTH-1:0] r_rd_dif;
   logic [WIDTH-1:0] r_rd_rem;

   div_t             r_dv [WIDTH+1];

   logic             r_fin_vld;
   logic [7:0]       r_fin_idx;
   logic [WIDTH-1:0] r_fin_rate;
   logic [WIDTH-1:0] r_fin_tgt;
   logic [WIDTH-1:0] r_fin_dif;
   logic [WIDTH-1:0] r_fin_rem;

   logic             r_out_vld;
   logic [WIDTH-1:0] r_out_rate;
   logic [7:0]       r_out_idx;

   logic             w_acc;
   logic [WIDTH-1:0] w_steps;
   logic [AW-1:0]    w_ra;
   logic [AW-1:0]    w_ca;
   logic [AW-1:0]    w_wa;
   logic [WIDTH-1:0] w_mod;
   logic [WIDTH-1:0] w_lin;
   logic [WIDTH-1:0] w_d;
   logic             w_chg;
   logic [WIDTH-1:0] w_num;
   logic [WIDTH-1:0] w_den;
   logic [WIDTH-1:0] w_rate;
   logic [WIDTH-1:0] w_rem;

   assign w_acc   = DIN_VALID & r_ready;
   // the channel 0 beat uses the live divisor, later beats the captured one
   assign w_steps = (r_cnt == 8'd0) ? COMPLETION_STEPS : r_steps;
   assign w_ra    = r_cnt[AW-1:0];
   assign w_ca    = r_clr[AW-1:0];
   assign w_wa    = r_fin_idx[AW-1:0];

   // one restoring-division bit per pipeline stage, MSB first
   function automatic div_t f_step(input div_t a);
      div_t           b;
      logic [WIDTH:0] sh;
      b     = a;
      sh    = {a.prem, a.num[WIDTH-1]};
      b.num = a.num << 1;
      if (sh >= {1'b0, a.den}) begin
         b.prem = WIDTH'(sh - {1'b0, a.den});
         b.quo  = {a.quo[WIDTH-2:0], 1'b1};
      end else begin
         b.prem = sh[WIDTH-1:0];
         b.quo  = {a.quo[WIDTH-2:0], 1'b0};
      end
      return b;
   endfunction

   always_comb begin
      w_mod = r_s1_tgt - r_rd_tgt;
      w_lin = (r_s1_tgt >= r_rd_tgt) ? w_mod
                                     : (r_rd_tgt - r_s1_tgt);
      // phase mode takes the shorter way round the circle
      if (PHASE_MODE != 0)
         w_d = (w_mod <= HALF) ? w_mod : (WIDTH'(0) - w_mod);
      else
         w_d = w_lin;
      w_chg = (w_d != '0);
      w_num = w_chg ? w_d : r_rd_dif;
      // dividing by one makes a zero step count jump in one update
      w_den = (r_s1_steps == '0) ? ONE : r_s1_steps;
   end

   always_comb begin
      w_rate = r_dv[WIDTH].quo;
      w_rem  = '0;
      if (r_dv[WIDTH].chg) begin
         w_rem = r_dv[WIDTH].prem;
      end else if (r_dv[WIDTH].srem != '0) begin
         w_rate = r_dv[WIDTH].quo + ONE;
         w_rem  = r_dv[WIDTH].srem - ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_CLEAR;
         r_ready <= 1'b0;
         r_clr   <= 8'd0;
         r_cnt   <= 8'd0;
         r_steps <= '0;
      end else begin
         unique case (r_state)
            S_CLEAR: begin
               r_clr <= r_clr + 8'd1;
               if (r_clr == LAST) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_acc) begin
                  r_cnt <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
                  if (r_cnt == 8'd0)
                     r_steps <= COMPLETION_STEPS;
               end
            end
            default: r_state <= S_CLEAR;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      r_rd_tgt <= r_mem_tgt[w_ra];
      r_rd_dif <= r_mem_dif[w_ra];
      r_rd_rem <= r_mem_rem[w_ra];
      if (r_state == S_CLEAR) begin
         r_mem_tgt[w_ca] <= '0;
         r_mem_dif[w_ca] <= '0;
         r_mem_rem[w_ca] <= '0;
      end else if (r_fin_vld && !RST) begin
         r_mem_tgt[w_wa] <= r_fin_tgt;
         r_mem_dif[w_wa] <= r_fin_dif;
         r_mem_rem[w_wa] <= r_fin_rem;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_s1_vld   <= 1'b0;
         r_s1_idx   <= 8'd0;
         r_s1_tgt   <= '0;
         r_s1_steps <= '0;
         for (int k = 0; k <= WIDTH; k++)
            r_dv[k] <= '0;
         r_fin_vld  <= 1'b0;
         r_fin_idx  <= 8'd0;
         r_fin_rate <= '0;
         r_fin_tgt  <= '0;
         r_fin_dif  <= '0;
         r_fin_rem  <= '0;
         r_out_vld  <= 1'b0;
         r_out_rate <= '0;
         r_out_idx  <= 8'd0;
      end else begin
         r_s1_vld   <= w_acc;
         r_s1_idx   <= r_cnt;
         r_s1_tgt   <= TARGET;
         r_s1_steps <= w_steps;

         r_dv[0].vld  <= r_s1_vld;
         r_dv[0].idx  <= r_s1_idx;
         r_dv[0].chg  <= w_chg;
         r_dv[0].tgt  <= r_s1_tgt;
         r_dv[0].dif  <= w_num;
         r_dv[0].srem <= r_rd_rem;
         r_dv[0].num  <= w_num;
         r_dv[0].den  <= w_den;
         r_dv[0].quo  <= '0;
         r_dv[0].prem <= '0;
         for (int k = 0; k < WIDTH; k++)
            r_dv[k+1] <= f_step(r_dv[k]);

         r_fin_vld  <= r_dv[WIDTH].vld;
         r_fin_idx  <= r_dv[WIDTH].idx;
         r_fin_rate <= w_rate;
         r_fin_tgt  <= r_dv[WIDTH].tgt;
         r_fin_dif  <= r_dv[WIDTH].dif;
         r_fin_rem  <= w_rem;

         r_out_vld <= r_fin_vld;
         if (r_fin_vld) begin
            r_out_rate <= r_fin_rate;
            r_out_idx  <= r_fin_idx;
         end
      end
   end

   assign READY       = r_ready;
   assign UPDATE_RATE = r_out_rate;
   assign DOUT_IDX    = r_out_idx;
   assign DOUT_VALID  = r_out_vld;

endmodule

// File: tb/tb_step_calculator_multi.sv
// tb_step_calculator_multi: scoreboard bench for step_calculator_multi.
// Drives a 16-bit linear instance and an 8-bit phase instance.
module tb_step_calculator_multi;

   localparam int W0 = 16;
   localparam int D0 = 249;
   localparam int W1 = 8;
   localparam int D1 = 16;

   typedef struct {
      int ecyc;
      int idx;
      int rate;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst0 = 1'b1;
   logic        dv0 = 1'b0;
   logic [15:0] st0 = '0;
   logic [15:0] tg0 = '0;
   logic        rdy0;
   logic [15:0] rate0;
   logic [7:0]  idx0;
   logic        ov0;

   logic        rst1 = 1'b1;
   logic        dv1 = 1'b0;
   logic [7:0]  st1 = '0;
   logic [7:0]  tg1 = '0;
   logic        rdy1;
   logic [7:0]  rate1;
   logic [7:0]  idx1;
   logic        ov1;

   step_calculator_multi #(
      .WIDTH(W0),
      .DEPTH(D0),
      .PHASE_MODE(0)
   ) dut0 (
      .CLK(clk),
      .RST(rst0),
      .DIN_VALID(dv0),
      .COMPLETION_STEPS(st0),
      .TARGET(tg0),
      .READY(rdy0),
      .UPDATE_RATE(rate0),
      .DOUT_IDX(idx0),
      .DOUT_VALID(ov0)
   );

   step_calculator_multi #(
      .WIDTH(W1),
      .DEPTH(D1),
      .PHASE_MODE(1)
   ) dut1 (
      .CLK(clk),
      .RST(rst1),
      .DIN_VALID(dv1),
      .COMPLETION_STEPS(st1),
      .TARGET(tg1),
      .READY(rdy1),
      .UPDATE_RATE(rate1),
      .DOUT_IDX(idx1),
      .DOUT_VALID(ov1)
   );

   int mprev [2][256];
   int mdiff [2][256];
   int mrem  [2][256];
   int mch   [2] = '{0, 0};
   int mstp  [2] = '{0, 0};
   int redge [2] = '{1, 1};
   exp_t q0 [$];
   exp_t q1 [$];
   int total = 0;
   int bad = 0;

   function automatic int dep(input int u);
      return (u != 0) ? D1 : D0;
   endfunction

   function automatic int lat(input int u);
      return (u != 0) ? W1 + 4 : W0 + 4;
   endfunction

   function automatic int qn(input int u);
      if (u != 0) return q1.size();
      return q0.size();
   endfunction

   function automatic exp_t qf(input int u);
      if (u != 0) return q1[0];
      return q0[0];
   endfunction

   function automatic void qpop(input int u);
      if (u != 0) void'(q1.pop_front());
      else void'(q0.pop_front());
   endfunction

   function automatic void push(input int u, input exp_t e);
      if (u != 0) q1.push_back(e);
      else q0.push_back(e);
   endfunction

   // outputs not yet on the port when reset hits are discarded
   function automatic void prune(input int u);
      if (u != 0) begin
         while (q1.size() > 0 && q1[$].ecyc > cyc)
            void'(q1.pop_back());
      end else begin
         while (q0.size() > 0 && q0[$].ecyc > cyc)
            void'(q0.pop_back());
      end
   endfunction

   task automatic model(input int u, input int ch, input int t,
                        input int s, output int rate);
      int m;
      int d;
      int pv;
      int dvd;
      int q;
      int r;
      m  = (u != 0) ? (1 << W1) : (1 << W0);
      pv = mprev[u][ch];
      if (u == 0) begin
         d = (t >= pv) ? t - pv : pv - t;
      end else begin
         d = (t - pv + m) % m;
         if (d > m / 2) d = m - d;
      end
      dvd = (d != 0) ? d : mdiff[u][ch];
      if (s == 0) begin
         q = dvd;
         r = 0;
      end else begin
         q = dvd / s;
         r = dvd % s;
      end
      if (d != 0) begin
         mprev[u][ch] = t;
         mdiff[u][ch] = d;
         mrem[u][ch]  = r;
         rate = q;
      end else if (mrem[u][ch] > 0) begin
         mrem[u][ch] = mrem[u][ch] - 1;
         rate = q + 1;
      end else begin
         rate = q;
      end
      rate = rate & (m - 1);
   endtask

   task automatic beat(input int u, input int t, input int s);
      int r;
      int ch;
      exp_t e;
      if (u == 0) begin
         dv0 = 1'b1;
         tg0 = 16'(t);
         st0 = 16'(s);
      end else begin
         dv1 = 1'b1;
         tg1 = 8'(t);
         st1 = 8'(s);
      end
      if (cyc + 1 >= redge[u] + dep(u) + 1) begin
         ch = mch[u];
         if (ch == 0) mstp[u] = s;
         model(u, ch, t, mstp[u], r);
         e.ecyc = cyc + lat(u);
         e.idx  = ch;
         e.rate = r;
         push(u, e);
         mch[u] = (ch + 1) % dep(u);
      end
      @(posedge clk);
      #1;
      if (u == 0) dv0 = 1'b0;
      else dv1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_rst(input int u);
      if (u == 0) rst0 = 1'b1;
      else rst1 = 1'b1;
      prune(u);
      for (int i = 0; i < 256; i++) begin
         mprev[u][i] = 0;
         mdiff[u][i] = 0;
         mrem[u][i]  = 0;
      end
      mch[u] = 0;
      @(posedge clk);
      #1;
      redge[u] = cyc;
      if (u == 0) rst0 = 1'b0;
      else rst1 = 1'b0;
   endtask

   task automatic wait_ready(input int u);
      while (cyc + 1 < redge[u] + dep(u) + 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame(input int u, input int t, input int s);
      for (int i = 0; i < dep(u); i++)
         beat(u, t, (mch[u] == 0) ? s : int'($urandom_range(0, 9)));
   endtask

   task automatic rnd_frame(input int u, input bit gaps, input int n);
      int s;
      int t;
      int mx;
      mx = (u != 0) ? 255 : 65535;
      s  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
         if (gaps) idle(int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) t = mprev[u][mch[u]];
         else t = int'($urandom_range(0, mx));
         beat(u, t, (mch[u] == 0) ? s : int'($urandom_range(0, 20)));
      end
   endtask

   task automatic chk(input int u, input logic v, input int ix,
                      input int rt, input logic rd);
      exp_t e;
      logic er;
      if (cyc < 1) return;
      er = (cyc >= redge[u] + dep(u));
      total++;
      if (rd !== er) begin
         bad++;
         $display("FAIL ready u%0d cyc=%0d got=%0b exp=%0b",
                  u, cyc, rd, er);
      end
      if (cyc == redge[u]) begin
         total++;
         if (v !== 1'b0 || ix != 0 || rt != 0) begin
            bad++;
            $display("FAIL rstval u%0d cyc=%0d got v=%0b i=%0d r=%0d exp 0",
                     u, cyc, v, ix, rt);
         end
      end
      while (qn(u) > 0 && qf(u).ecyc < cyc) begin
         e = qf(u);
         qpop(u);
         total++;
         bad++;
         $display("FAIL missing u%0d cyc=%0d got none exp idx=%0d at %0d",
                  u, cyc, e.idx, e.ecyc);
      end
      if (v === 1'b1) begin
         if (qn(u) == 0 || qf(u).ecyc != cyc) begin
            total++;
            bad++;
            $display("FAIL unexpected u%0d cyc=%0d got idx=%0d exp none",
                     u, cyc, ix);
         end else begin
            e = qf(u);
            qpop(u);
            total++;
            if (ix != e.idx) begin
               bad++;
               $display("FAIL idx u%0d cyc=%0d got=%0d exp=%0d",
                        u, cyc, ix, e.idx);
            end
            total++;
            if (rt != e.rate) begin
               bad++;
               $display("FAIL rate u%0d cyc=%0d idx=%0d got=%0d exp=%0d",
                        u, cyc, e.idx, rt, e.rate);
            end
         end
      end else if (v !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL xvalid u%0d cyc=%0d got=%0b exp=0/1", u, cyc, v);
      end
   endtask

   always @(negedge clk) begin
      chk(0, ov0, int'(idx0), int'(rate0), rdy0);
      chk(1, ov1, int'(idx1), int'(rate1), rdy1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got timeout exp finish", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;

      // beats offered during clear are dropped
      while (cyc + 1 < redge[0] + D0 + 1) beat(0, 1000, 3);
      for (int f = 0; f < 5; f++) frame(0, 1000, 3);

      do_rst(0);
      wait_ready(0);
      frame(0, 700, 0);
      frame(0, 700, 0);

      rnd_frame(0, 1'b0, D0);
      rnd_frame(0, 1'b1, D0);
      rnd_frame(0, 1'b1, 100);
      do_rst(0);
      wait_ready(0);
      frame(0, 50, 5);
      rnd_frame(0, 1'b1, D0);

      do_rst(1);
      wait_ready(1);
      frame(1, 250, 2);
      frame(1, 4, 2);
      frame(1, 4, 2);
      do_rst(1);
      wait_ready(1);
      frame(1, 128, 2);
      for (int f = 0; f < 8; f++) rnd_frame(1, 1'b1, D1);
      rnd_frame(1, 1'b0, 5);
      do_rst(1);
      while (cyc + 1 < redge[1] + D1 + 1) beat(1, 77, 7);
      frame(1, 200, 7);

      idle(40);
      total++;
      if (q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL leftover got=%0d/%0d exp=0/0",
                  q0.size(), q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/step_calculator_multi.md
# step_calculator_multi

Parametrised per-channel step-rate calculator for the silencer. It streams DEPTH channel targets per frame and keeps each channel's last target, |difference| and division remainder in internal memories. For each channel it emits the per-update increment that reaches the new target in COMPLETION_STEPS updates. It generalises the fixed 16-bit intensity calculator with these additions:
- configurable width and depth;
- a wrap-around phase mode that takes the shortest path;
- a divide-by-zero guard;
- a synchronous reset that clears all channel state.

## Interface
- WIDTH, 16: bit width of targets, differences, rates and remainders (4..16).
- DEPTH, 249: channels per frame; must satisfy DEPTH >= LATENCY + 2 and DEPTH <= 256.
- PHASE_MODE, 0: 0 = linear (intensity) difference; 1 = modular 2^WIDTH (phase) difference.
- LATENCY (localparam) = WIDTH + 4: input beat to output beat, in cycles.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- DIN_VALID  in  1  one channel beat per cycle when high.
- COMPLETION_STEPS  in  WIDTH  steps to reach the target; sampled on channel 0 beat, held for frame.
- TARGET  in  WIDTH  new target for the current channel.
- READY  out  1  high when beats are accepted; low during clear.
- UPDATE_RATE  out  WIDTH  per-update increment magnitude.
- DOUT_IDX  out  8  channel index of UPDATE_RATE.
- DOUT_VALID  out  1  one-cycle strobe per output beat.

## Operation
- States:
  - CLEAR: entered on RST or at power-up. Writes 0 to target, diff and remainder for addresses 0..DEPTH-1, one per cycle, for DEPTH cycles. READY=0, then goes to RUN.
  - RUN: READY=1.
- RST in any state aborts in-flight beats, flushes pipeline valids, zeroes the channel counter and re-enters CLEAR.
- Beats with DIN_VALID=1 while READY=0 are dropped.
- Channel counter increments on each accepted beat and wraps DEPTH-1 -> 0. Gaps between beats are allowed; beats are never reordered.
- Per beat, with prev = stored target and T = TARGET:
  - Linear: d = |T - prev|.
  - Phase: m = (T - prev) mod 2^WIDTH; d = m if m <= 2^(WIDTH-1), else 2^WIDTH - m.
  - Changed (d != 0): store T and d; divide d by the frame's COMPLETION_STEPS giving q, r. Output q, store remainder r. No +1 on the first update.
  - Unchanged (d == 0): divide the stored diff by COMPLETION_STEPS giving q. If stored rem > 0, output q+1 and store rem-1; otherwise output q and store 0.
- COMPLETION_STEPS == 0: q = divisor operand, r = 0, so the channel jumps in one update.
- Arithmetic is unsigned WIDTH bits, with no overflow: d <= 2^WIDTH-1, and q+1 <= d holds whenever rem > 0.
- Hazard rule: a channel's memory write completes before that channel's next beat. This is guaranteed by DEPTH >= LATENCY+2; no forwarding is required.

## Timing
- Reset values:
  - READY=0, DOUT_VALID=0, UPDATE_RATE=0, DOUT_IDX=0.
  - First RUN cycle is DEPTH cycles after RST deasserts.
- Accepted beat at cycle t gives DOUT_VALID=1 at t+LATENCY, with UPDATE_RATE and DOUT_IDX valid in the same cycle.
- DOUT_VALID pattern equals the accepted-beat pattern delayed by LATENCY.
- Divider is fully pipelined: one result per cycle, sustained at DEPTH beats in DEPTH consecutive cycles.
- COMPLETION_STEPS is captured on a channel 0 beat. Later beats of the frame use the captured value even if the input changes.

## Test plan
- Reset then frame: RST 1 cycle. READY rises after DEPTH cycles. Then 249 contiguous beats, TARGET=1000, steps=3 -> 249 outputs at LATENCY offset, each rate 333 with remainder 1 stored, DOUT_IDX 0..248.
- Remainder drain: after the frame above, 3 frames TARGET=1000, steps=3 -> rates 334, 333, 333. Fourth frame -> 333 (stored diff reused, rem 0).
- Phase wrap, WIDTH=8, PHASE_MODE=1: prev=250, T=4, steps=2 -> d=10, rate 5. prev=0, T=128 -> d=128.
- Divide-by-zero: steps=0, prev=0, T=700 -> rate 700, rem 0. Next unchanged frame -> rate 700.
- Gapped input plus mid-frame RST:
  - Beats with random 0–3-cycle gaps -> outputs keep the same gaps at LATENCY offset.
  - RST at beat 100 -> no DOUT_VALID after RST, READY low for DEPTH cycles.
  - Next frame TARGET=50, steps=5 -> rate 10 on all channels (state cleared to 0).
- Beats during CLEAR: DIN_VALID held high during CLEAR -> no outputs; channel counter still 0 at the first RUN beat.
